// File: rtl/armleocpu_mul_ctrl_if.sv
// Handshake bundle between the execute stage, the multiply sequencer and the iterative multiplier.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface armleocpu_mul_ctrl_if;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_kill;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        mult_valid;
    logic [31:0] mult_factor0;
    logic [31:0] mult_factor1;
    logic        mult_ready;
    logic [63:0] mult_result;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_kill, mult_ready, mult_result,
        output busy, resp_valid, resp_data, mult_valid, mult_factor0, mult_factor1
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_kill, mult_ready, mult_result,
        input  busy, resp_valid, resp_data, mult_valid, mult_factor0, mult_factor1
    );
endinterface

// File: rtl/armleocpu_mul_ctrl.sv
// Multiply sequencer: decodes MUL/MULH/MULHSU/MULHU, drives an unsigned multiplier, sign-corrects, caches last product.
// Latency: cache hit 1 cycle; miss = one cycle after mult_ready. Requests are only taken while busy is low.
module armleocpu_mul_ctrl (
    input  logic                       clk,
    input  logic                       rst_n,
    armleocpu_mul_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_t      r_state, w_state_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_resp_valid, w_resp_valid_nxt;
    logic [31:0] r_resp_data, w_resp_data_nxt;
    logic        r_mult_valid, w_mult_valid_nxt;
    logic [31:0] r_factor0, w_factor0_nxt;
    logic [31:0] r_factor1, w_factor1_nxt;
    logic [1:0]  r_op, w_op_nxt;
    logic        r_neg, w_neg_nxt;
    logic [31:0] r_ka, w_ka_nxt;
    logic [31:0] r_kb, w_kb_nxt;
    logic        r_ksa, w_ksa_nxt;
    logic        r_ksb, w_ksb_nxt;
    logic        r_kill, w_kill_nxt;
    logic        r_cv, w_cv_nxt;
    logic [31:0] r_ca, w_ca_nxt;
    logic [31:0] r_cb, w_cb_nxt;
    logic        r_csa, w_csa_nxt;
    logic        r_csb, w_csb_nxt;
    logic [63:0] r_cprod, w_cprod_nxt;

    logic        w_sa, w_sb, w_neg_a, w_neg_b, w_hit;
    logic [31:0] w_mag_a, w_mag_b, w_hit_data, w_res_data;
    logic [63:0] w_prod;

    assign w_sa    = (bus.req_op == OP_MULH) || (bus.req_op == OP_MULHSU);
    assign w_sb    = (bus.req_op == OP_MULH);
    assign w_neg_a = w_sa & bus.req_a[31];
    assign w_neg_b = w_sb & bus.req_b[31];
    assign w_mag_a = w_neg_a ? (~bus.req_a + 32'd1) : bus.req_a;
    assign w_mag_b = w_neg_b ? (~bus.req_b + 32'd1) : bus.req_b;

    // Low half of the product does not depend on signedness, so MUL may reuse any cached pass.
    assign w_hit = r_cv && (bus.req_a == r_ca) && (bus.req_b == r_cb) &&
                   ((bus.req_op == OP_MUL) || ((w_sa == r_csa) && (w_sb == r_csb)));
    assign w_hit_data = (bus.req_op == OP_MUL) ? r_cprod[31:0] : r_cprod[63:32];

    assign w_prod     = r_neg ? (~bus.mult_result + 64'd1) : bus.mult_result;
    assign w_res_data = (r_op == OP_MUL) ? w_prod[31:0] : w_prod[63:32];

    always_comb begin
        w_state_nxt      = r_state;
        w_resp_valid_nxt = 1'b0;
        w_resp_data_nxt  = r_resp_data;
        w_mult_valid_nxt = 1'b0;
        w_factor0_nxt    = r_factor0;
        w_factor1_nxt    = r_factor1;
        w_op_nxt         = r_op;
        w_neg_nxt        = r_neg;
        w_ka_nxt         = r_ka;
        w_kb_nxt         = r_kb;
        w_ksa_nxt        = r_ksa;
        w_ksb_nxt        = r_ksb;
        w_kill_nxt       = r_kill;
        w_cv_nxt         = r_cv;
        w_ca_nxt         = r_ca;
        w_cb_nxt         = r_cb;
        w_csa_nxt        = r_csa;
        w_csb_nxt        = r_csb;
        w_cprod_nxt      = r_cprod;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && !bus.req_kill) begin
                    if (w_hit) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_data_nxt  = w_hit_data;
                    end else begin
                        w_state_nxt      = S_ISSUE;
                        w_mult_valid_nxt = 1'b1;
                        w_factor0_nxt    = w_mag_a;
                        w_factor1_nxt    = w_mag_b;
                        w_op_nxt         = bus.req_op;
                        w_neg_nxt        = w_neg_a ^ w_neg_b;
                        w_ka_nxt         = bus.req_a;
                        w_kb_nxt         = bus.req_b;
                        w_ksa_nxt        = w_sa;
                        w_ksb_nxt        = w_sb;
                    end
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                if (bus.req_kill) begin
                    w_kill_nxt = 1'b1;
                    w_cv_nxt   = 1'b0;
                end
            end
            S_WAIT: begin
                if (bus.req_kill) begin
                    w_kill_nxt = 1'b1;
                    w_cv_nxt   = 1'b0;
                end
                // A kill arriving together with mult_ready still discards the result.
                if (bus.mult_ready) begin
                    w_state_nxt = S_IDLE;
                    w_kill_nxt  = 1'b0;
                    if (!(r_kill || bus.req_kill)) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_data_nxt  = w_res_data;
                        w_cv_nxt         = 1'b1;
                        w_ca_nxt         = r_ka;
                        w_cb_nxt         = r_kb;
                        w_csa_nxt        = r_ksa;
                        w_csb_nxt        = r_ksb;
                        w_cprod_nxt      = w_prod;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            r_mult_valid <= 1'b0;
            r_factor0    <= 32'd0;
            r_factor1    <= 32'd0;
            r_op         <= 2'd0;
            r_neg        <= 1'b0;
            r_ka         <= 32'd0;
            r_kb         <= 32'd0;
            r_ksa        <= 1'b0;
            r_ksb        <= 1'b0;
            r_kill       <= 1'b0;
            r_cv         <= 1'b0;
            r_ca         <= 32'd0;
            r_cb         <= 32'd0;
            r_csa        <= 1'b0;
            r_csb        <= 1'b0;
            r_cprod      <= 64'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= w_busy_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_mult_valid <= w_mult_valid_nxt;
            r_factor0    <= w_factor0_nxt;
            r_factor1    <= w_factor1_nxt;
            r_op         <= w_op_nxt;
            r_neg        <= w_neg_nxt;
            r_ka         <= w_ka_nxt;
            r_kb         <= w_kb_nxt;
            r_ksa        <= w_ksa_nxt;
            r_ksb        <= w_ksb_nxt;
            r_kill       <= w_kill_nxt;
            r_cv         <= w_cv_nxt;
            r_ca         <= w_ca_nxt;
            r_cb         <= w_cb_nxt;
            r_csa        <= w_csa_nxt;
            r_csb        <= w_csb_nxt;
            r_cprod      <= w_cprod_nxt;
        end
    end

    assign bus.busy         = r_busy;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_data    = r_resp_data;
    assign bus.mult_valid   = r_mult_valid;
    assign bus.mult_factor0 = r_factor0;
    assign bus.mult_factor1 = r_factor1;
endmodule

// File: tb/tb_armleocpu_mul_ctrl.sv
// Bench for armleocpu_mul_ctrl: multiplier stub, transaction-level reference model, per-cycle compare, directed vectors.
module tb_armleocpu_mul_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    armleocpu_mul_ctrl_if bus();
    armleocpu_mul_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Multiplier stub: ready pulse mdelay cycles after the start pulse.
    int mdelay = 3;
    int mcnt = 0;
    int mv_count = 0;
    initial begin
        bus.mult_ready  = 1'b0;
        bus.mult_result = 64'd0;
        forever begin
            @(posedge clk);
            #2;
            bus.mult_ready = 1'b0;
            if (!rst_n) begin
                mcnt = 0;
            end else begin
                if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        bus.mult_ready  = 1'b1;
                        bus.mult_result = {32'h0, bus.mult_factor0} * {32'h0, bus.mult_factor1};
                    end
                end
                if (bus.mult_valid) begin
                    mcnt = mdelay;
                    mv_count++;
                end
            end
        end
    end

    function automatic logic [63:0] full_prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] pa, pb;
        pa = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        pb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        return pa * pb;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] op, input logic [63:0] p);
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] mag(input logic s, input logic [31:0] x);
        return (s && x[31]) ? (32'h0 - x) : x;
    endfunction

    // Reference model state and expected outputs.
    logic        m_busy, m_kill, m_cv, m_csa, m_csb, msa, msb, mhit;
    logic [1:0]  m_op;
    logic [31:0] m_a, m_b, m_ca, m_cb;
    logic [63:0] m_cprod, mp;
    logic        e_busy, e_rv, e_mv;
    logic [31:0] e_data, e_f0, e_f1;
    bit          chk_en = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_kill = 0; m_cv = 0;
            e_busy = 0; e_rv = 0; e_mv = 0;
            e_data = 0; e_f0 = 0; e_f1 = 0;
            chk_en = 1;
        end else begin
            e_rv = 0;
            e_mv = 0;
            if (!m_busy) begin
                if (bus.req_valid && !bus.req_kill) begin
                    msa  = (bus.req_op == 2'd1) || (bus.req_op == 2'd2);
                    msb  = (bus.req_op == 2'd1);
                    mhit = m_cv && bus.req_a == m_ca && bus.req_b == m_cb &&
                           (bus.req_op == 2'd0 || (msa == m_csa && msb == m_csb));
                    if (mhit) begin
                        e_rv   = 1;
                        e_data = pick(bus.req_op, m_cprod);
                    end else begin
                        m_busy = 1;
                        m_op = bus.req_op; m_a = bus.req_a; m_b = bus.req_b;
                        e_mv = 1;
                        e_f0 = mag(msa, bus.req_a);
                        e_f1 = mag(msb, bus.req_b);
                    end
                end
            end else begin
                if (bus.req_kill) begin
                    m_kill = 1;
                    m_cv = 0;
                end
                if (bus.mult_ready) begin
                    if (!m_kill) begin
                        mp      = full_prod(m_op, m_a, m_b);
                        e_rv    = 1;
                        e_data  = pick(m_op, mp);
                        m_cv    = 1;
                        m_ca    = m_a;
                        m_cb    = m_b;
                        m_csa   = (m_op == 2'd1) || (m_op == 2'd2);
                        m_csb   = (m_op == 2'd1);
                        m_cprod = mp;
                    end
                    m_busy = 0;
                    m_kill = 0;
                end
            end
            e_busy = m_busy;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", bus.busy, e_busy);
            check("resp_valid", bus.resp_valid, e_rv);
            check("mult_valid", bus.mult_valid, e_mv);
            check("mult_factor0", bus.mult_factor0, e_f0);
            check("mult_factor1", bus.mult_factor1, e_f1);
            if (e_rv) check("resp_data", bus.resp_data, e_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_data, input int exp_lat, input int exp_mv);
        int n;
        int mv0;
        mv0 = mv_count;
        set_req(1'b1, op, a, b);
        step();
        bus.req_valid = 1'b0;
        n = 1;
        while (n < 60) begin
            @(negedge clk);
            if (bus.resp_valid) break;
            step();
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(exp_lat));
        check({name, " data"}, {32'h0, bus.resp_data}, {32'h0, exp_data});
        check({name, " mult pulses"}, 64'(mv_count - mv0), 64'(exp_mv));
        step();
    endtask

    int mvb;

    initial begin
        bus.req_kill = 1'b0;
        set_req(1'b0, 2'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset resp_valid", bus.resp_valid, 0);
        check("reset mult_valid", bus.mult_valid, 0);
        check("reset resp_data", bus.resp_data, 0);
        check("reset factor0", bus.mult_factor0, 0);
        step();

        run_op("mulhu max", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 1);
        check("mulhu f0", bus.mult_factor0, 32'hFFFFFFFF);
        check("mulhu f1", bus.mult_factor1, 32'hFFFFFFFF);
        run_op("mulhu hit", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0);
        run_op("mul hit", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1, 0);
        run_op("mulh min", 2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 5, 1);
        check("mulh f0", bus.mult_factor0, 32'h80000000);
        check("mulh f1", bus.mult_factor1, 32'h80000000);
        run_op("mulhsu", 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1);
        check("mulhsu f0", bus.mult_factor0, 32'h00000001);
        check("mulhsu f1", bus.mult_factor1, 32'hFFFFFFFF);
        run_op("mul miss", 2'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 5, 1);

        // MULH then fused MUL accepted in the response cycle.
        set_req(1'b1, 2'd1, 32'hFFFFFFFE, 32'h00000003);
        step();
        bus.req_valid = 1'b0;
        repeat (4) step();
        set_req(1'b1, 2'd0, 32'hFFFFFFFE, 32'h00000003);
        mvb = mv_count;
        @(negedge clk);
        check("fuse mulh valid", bus.resp_valid, 1);
        check("fuse mulh data", bus.resp_data, 32'hFFFFFFFF);
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("fuse mul valid", bus.resp_valid, 1);
        check("fuse mul data", bus.resp_data, 32'hFFFFFFFA);
        check("fuse mul pulses", 64'(mv_count - mvb), 0);
        step();
        run_op("mulhu after fuse", 2'd3, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 5, 1);

        mdelay = 6;
        run_op("slow mult", 2'd0, 32'h00012345, 32'h00000010, 32'h00123450, 8, 1);
        mdelay = 3;

        // Kill in IDLE: request not taken.
        set_req(1'b1, 2'd0, 32'h00000009, 32'h00000009);
        bus.req_kill = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.req_kill = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle kill busy", bus.busy, 0);
            check("idle kill resp", bus.resp_valid, 0);
            step();
        end

        // Kill in WAIT (cycle 2).
        set_req(1'b1, 2'd0, 32'h00000005, 32'h00000006);
        step();
        bus.req_valid = 1'b0;
        step();
        bus.req_kill = 1'b1;
        step();
        bus.req_kill = 1'b0;
        @(negedge clk);
        check("kill busy c3", bus.busy, 1);
        step();
        @(negedge clk);
        check("kill busy c4", bus.busy, 1);
        step();
        @(negedge clk);
        check("kill busy c5", bus.busy, 0);
        check("kill resp c5", bus.resp_valid, 0);
        step();
        run_op("after kill cached", 2'd0, 32'h00012345, 32'h00000010, 32'h00123450, 5, 1);
        run_op("after kill repeat", 2'd0, 32'h00000005, 32'h00000006, 32'h0000001E, 5, 1);

        // Reset during WAIT.
        set_req(1'b1, 2'd3, 32'h00000003, 32'h00000004);
        step();
        bus.req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        check("rst busy", bus.busy, 0);
        check("rst resp_valid", bus.resp_valid, 0);
        check("rst mult_valid", bus.mult_valid, 0);
        check("rst resp_data", bus.resp_data, 0);
        check("rst factor0", bus.mult_factor0, 0);
        check("rst factor1", bus.mult_factor1, 0);
        rst_n = 1'b1;
        step();
        step();
        run_op("after reset", 2'd0, 32'h00000005, 32'h00000006, 32'h0000001E, 5, 1);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
